// File: rtl/cam_dvp_tx_if.sv
// rtl/cam_dvp_tx_if.sv - source byte stream into the DVP transmitter
interface cam_dvp_tx_if;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;

  modport master (output din, output din_valid, input  din_ready);
  modport slave  (input  din, input  din_valid, output din_ready);
endinterface

// File: rtl/cam_dvp_tx.sv
// rtl/cam_dvp_tx.sv - DVP camera timing generator: emits vsync/href/data frames from a byte source
module cam_dvp_tx #(
  parameter int HACT    = 1280,
  parameter int HBLANK  = 144,
  parameter int VACT    = 480,
  parameter int VSYNC_L = 3,
  parameter int VBP_L   = 17,
  parameter int VFP_L   = 10
) (
  input  logic         pclk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  cam_dvp_tx_if.slave  src,
  output logic         cam_vsync,
  output logic         cam_href,
  output logic [7:0]   cam_dout,
  output logic         busy,
  output logic         underflow_err,
  output logic [15:0]  frame_cnt
);

  localparam int LT = HACT + HBLANK;
  localparam logic [15:0] VSYNC_M1 = 16'(VSYNC_L * LT - 1);
  localparam logic [15:0] VBP_M1   = 16'(VBP_L * LT - 1);
  localparam logic [15:0] VFP_M1   = 16'(VFP_L * LT - 1);
  localparam logic [15:0] HACT_M1  = 16'(HACT - 1);
  localparam logic [15:0] HBL_M1   = 16'(HBLANK - 1);
  localparam logic [15:0] VACT_M1  = 16'(VACT - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_VSYNC, ST_VBP, ST_ACT, ST_HBL, ST_VFP
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] line_q, line_d;
  logic        running_q, running_d;
  logic        vsync_q, vsync_d;
  logic        href_q, href_d;
  logic [7:0]  dout_q, dout_d;
  logic        uflow_q, uflow_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic        xfer;

  assign src.din_ready = (state_q == ST_ACT);
  assign xfer          = src.din_valid && src.din_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 16'd1;
    line_d    = line_q;
    running_d = running_q;
    fcnt_d    = fcnt_q;
    vsync_d   = (state_q == ST_VSYNC);
    href_d    = (state_q == ST_ACT);
    dout_d    = xfer ? src.din : 8'h00;
    // A starved byte slot still consumes its cycle; the line is never stretched.
    uflow_d   = uflow_q | ((state_q == ST_ACT) && !src.din_valid);

    if (state_q != ST_IDLE && stop) running_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d  = 16'd0;
        line_d = 16'd0;
        if (start && !stop) begin
          state_d   = ST_VSYNC;
          running_d = 1'b1;
          uflow_d   = 1'b0;
        end
      end
      ST_VSYNC: if (cnt_q == VSYNC_M1) begin
        state_d = ST_VBP;
        cnt_d   = 16'd0;
      end
      ST_VBP: if (cnt_q == VBP_M1) begin
        state_d = ST_ACT;
        cnt_d   = 16'd0;
        line_d  = 16'd0;
      end
      ST_ACT: if (cnt_q == HACT_M1) begin
        state_d = ST_HBL;
        cnt_d   = 16'd0;
      end
      ST_HBL: if (cnt_q == HBL_M1) begin
        cnt_d = 16'd0;
        if (line_q == VACT_M1) begin
          state_d = ST_VFP;
        end else begin
          state_d = ST_ACT;
          line_d  = line_q + 16'd1;
        end
      end
      ST_VFP: if (cnt_q == VFP_M1) begin
        cnt_d   = 16'd0;
        fcnt_d  = fcnt_q + 16'd1;
        state_d = running_d ? ST_VSYNC : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 16'd0;
      line_q    <= 16'd0;
      running_q <= 1'b0;
      vsync_q   <= 1'b0;
      href_q    <= 1'b0;
      dout_q    <= 8'h00;
      uflow_q   <= 1'b0;
      fcnt_q    <= 16'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      line_q    <= line_d;
      running_q <= running_d;
      vsync_q   <= vsync_d;
      href_q    <= href_d;
      dout_q    <= dout_d;
      uflow_q   <= uflow_d;
      fcnt_q    <= fcnt_d;
    end
  end

  wire frame_cnt_q_unused = 1'b0;
  assign cam_vsync     = vsync_q;
  assign cam_href      = href_q;
  assign cam_dout      = dout_q;
  assign busy          = (state_q != ST_IDLE);
  assign underflow_err = uflow_q;
  assign frame_cnt     = fcnt_q;

  logic [15:0] frame_cnt_q;
  assign frame_cnt_q = fcnt_q;

endmodule

// File: tb/tb_cam_dvp_tx.sv
// tb/tb_cam_dvp_tx.sv - frame-position reference model bench for cam_dvp_tx
module tb_cam_dvp_tx;
  localparam int HACT = 4, HBLANK = 2, VACT = 2, VS = 1, VB = 1, VF = 1;
  localparam int LT = HACT + HBLANK;
  localparam int FRAME = (VS + VB + VF) * LT + VACT * LT;

  logic        pclk = 1'b0;
  logic        rst, start, stop;
  logic        cam_vsync, cam_href, busy, underflow_err;
  logic [7:0]  cam_dout;
  logic [15:0] frame_cnt;

  cam_dvp_tx_if src ();

  cam_dvp_tx #(.HACT(HACT), .HBLANK(HBLANK), .VACT(VACT),
               .VSYNC_L(VS), .VBP_L(VB), .VFP_L(VF)) dut (
    .pclk(pclk), .rst(rst), .start(start), .stop(stop), .src(src),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_dout(cam_dout),
    .busy(busy), .underflow_err(underflow_err), .frame_cnt(frame_cnt)
  );

  always #5 pclk = ~pclk;

  int          nvec = 0, nerr = 0;
  int          pos = -1;
  bit          run = 1'b0;
  logic        uflow = 1'b0;
  logic [15:0] fcnt = 16'd0;
  logic [7:0]  next_byte = 8'h10;
  bit          seq_mode = 1'b1;
  int          cyc = -1;
  int          rises[$];
  logic        prev_vs = 1'b0;

  // Phase of a frame position: 0 idle, 1 vsync, 2 back porch, 3 active, 4 hblank, 5 front porch
  function automatic int phase(int p);
    if (p < 0) return 0;
    if (p < VS * LT) return 1;
    p -= VS * LT;
    if (p < VB * LT) return 2;
    p -= VB * LT;
    if (p < VACT * LT) return ((p % LT) < HACT) ? 3 : 4;
    return 5;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_vsync"}, 32'(cam_vsync), 32'd0);
    chk({tag, "_href"},  32'(cam_href), 32'd0);
    chk({tag, "_dout"},  32'(cam_dout), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_uflow"}, 32'(underflow_err), 32'd0);
    chk({tag, "_fcnt"},  32'(frame_cnt), 32'd0);
    chk({tag, "_ready"}, 32'(src.din_ready), 32'd0);
  endtask

  task automatic model_reset();
    pos = -1; run = 1'b0; uflow = 1'b0; fcnt = 16'd0; prev_vs = 1'b0;
    rises.delete();
  endtask

  task automatic step(bit st, bit sp, bit vl);
    int         ph;
    logic       e_vs, e_hr, e_busy;
    logic [7:0] e_do;
    @(negedge pclk);
    start = st; stop = sp; src.din_valid = vl; src.din = next_byte;
    ph = phase(pos);
    #1 chk("din_ready", 32'(src.din_ready), 32'(ph == 3));
    e_vs = (ph == 1);
    e_hr = (ph == 3);
    e_do = 8'h00;
    if (ph == 3) begin
      if (vl) begin
        e_do = next_byte;
        next_byte = seq_mode ? next_byte + 8'd1 : 8'($urandom);
      end else begin
        uflow = 1'b1;
      end
    end
    if (pos < 0) begin
      if (st && !sp) begin pos = 0; run = 1'b1; uflow = 1'b0; end
    end else begin
      if (sp) run = 1'b0;
      pos++;
      if (pos == FRAME) begin
        fcnt++;
        pos = run ? 0 : -1;
      end
    end
    e_busy = (pos >= 0);
    @(posedge pclk);
    #1;
    cyc++;
    chk("cam_vsync", 32'(cam_vsync), 32'(e_vs));
    chk("cam_href", 32'(cam_href), 32'(e_hr));
    chk("cam_dout", 32'(cam_dout), 32'(e_do));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("underflow_err", 32'(underflow_err), 32'(uflow));
    chk("frame_cnt", 32'(frame_cnt), 32'(fcnt));
    if (cam_vsync && !prev_vs) rises.push_back(cyc);
    prev_vs = cam_vsync;
  endtask

  task automatic do_reset();
    @(negedge pclk);
    rst = 1'b1; start = 1'b0; stop = 1'b0; src.din_valid = 1'b0;
    @(posedge pclk);
    #1 chk_all_zero("reset");
    @(negedge pclk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drain();
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < FRAME + 2; i++) step(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    src.din = 8'h00; src.din_valid = 1'b0;
    repeat (2) @(posedge pclk);
    #1 chk_all_zero("por");
    @(negedge pclk);
    rst = 1'b0;

    // Nominal continuous output, sequential bytes from 0x10
    next_byte = 8'h10; cyc = -1;
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 35; i++) step(1'b0, 1'b0, 1'b1);
    chk("first_vsync_cycle", 32'(rises[0]), 32'd1);
    chk("vsync_period", 32'(rises[1] - rises[0]), 32'd30);
    drain();

    // Stop during first active line: one frame only
    do_reset();
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 13; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b1);
    chk("stop_frames", 32'(frame_cnt), 32'd1);
    chk("stop_vsyncs", 32'(rises.size()), 32'd1);
    chk("stop_idle", 32'(busy), 32'd0);

    // Starved second byte of line 1
    do_reset();
    next_byte = 8'h10;
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, !(pos == 13));
    chk("uflow_sticky", 32'(underflow_err), 32'd1);
    drain();
    chk("uflow_idle", 32'(underflow_err), 32'd1);
    step(1'b1, 1'b0, 1'b1);
    chk("uflow_cleared", 32'(underflow_err), 32'd0);
    drain();

    // Asynchronous reset in the middle of an active line
    do_reset();
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 1'b1);
    @(negedge pclk);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    @(negedge pclk);
    rst = 1'b0;
    model_reset();
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1);
    drain();

    // Ignored starts: with stop in idle, and repeated mid-frame
    do_reset();
    step(1'b1, 1'b1, 1'b1);
    chk("start_with_stop", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 60; i++) step(1'b0, 1'b0, 1'b1);
    chk("restart_period1", 32'(rises[1] - rises[0]), 32'd30);
    chk("restart_period2", 32'(rises[2] - rises[1]), 32'd30);
    drain();

    // Frame counter wrap from 0xFFFF
    do_reset();
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
    force dut.frame_cnt_q = 16'hFFFF;
    force dut.fcnt_q = 16'hFFFF;
    fcnt = 16'hFFFF;
    step(1'b0, 1'b0, 1'b1);
    release dut.fcnt_q;
    release dut.frame_cnt_q;
    for (int i = 0; i < 25; i++) step(1'b0, 1'b0, 1'b1);
    chk("fcnt_wrap", 32'(frame_cnt), 32'd0);
    drain();

    // Random valid gaps with sparse start/stop requests
    do_reset();
    seq_mode = 1'b0;
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 29) == 0, $urandom_range(0, 59) == 0, $urandom_range(0, 4) != 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
